// File: rtl/spi_tx_pkg.sv
// Shared definitions for the SPI mode-0 transmitter.
//
// Contents:
//   SPI_WORD_WIDTH  default word width; the receiving spi_slave uses the same value
//   state_t         FSM state encoding used by spi_master_tx (also exposed on its debug port)
//   ST_*            state constants: IDLE, LOW (spi_clk low phase), HIGH (spi_clk high phase),
//                   GAP (inter-word spacing)
package spi_tx_pkg;

    localparam int SPI_WORD_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter used for spi_clk phase timing and inter-word gap timing.
//
// Ports:
//   clk       in   1      system clock
//   reset_n   in   1      asynchronous active-low reset
//   load      in   1      load load_val this cycle (takes priority over counting)
//   load_val  in   WIDTH  number of cycles the next interval lasts
//   expire    out  1      high in the last cycle of the loaded interval
//
// Loading N at a clock edge makes expire rise in the Nth cycle after that edge, so a state
// that loads N on entry and leaves on expire lasts exactly N cycles. The counter stops at 0
// instead of wrapping, so an unloaded timer never raises expire.
module spi_half_period_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 (CPOL=0, CPHA=0) transmitter, MSB first.
//
// Parameters:
//   WORD_WIDTH  bits per word (>= 3)
//   CLK_DIV     clk cycles per spi_clk half-period, 1..255
//   GAP_CYCLES  clk cycles spi_clk stays low after a word before in_ready returns, 0..255
//
// Ports:
//   clk        in   1           system clock
//   reset_n    in   1           asynchronous active-low reset
//   in_data    in   WORD_WIDTH  word to send, sampled on the accepting edge
//   in_valid   in   1           in_data is valid
//   in_ready   out  1           idle and able to accept a word
//   spi_clk    out  1           serial clock, idles low
//   spi_mosi   out  1           serial data, changes only while spi_clk is low
//   busy       out  1           high from acceptance until return to IDLE
//   word_done  out  1           one-cycle pulse in the last cycle of the final bit's high phase
//   spi_cs_n   out  1           chip select, only when SPI_TX_CS_EN is defined
//   fsm_state  out  2           current FSM state (debug visibility)
//
// Optional feature macro: SPI_TX_CS_EN adds spi_cs_n (low from acceptance to GAP entry).
// With it defined, GAP_CYCLES must be at least 1 so chip select is seen high between words.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready. in_ready is a
// registered flag that is only high in IDLE; in_valid while busy is ignored and nothing is
// buffered, so in_data need not be held after the accepting edge.
module spi_master_tx
    import spi_tx_pkg::*;
#(
    parameter int WORD_WIDTH = SPI_WORD_WIDTH,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  busy,
    output logic                  word_done,
`ifdef SPI_TX_CS_EN
    output logic                  spi_cs_n,
`endif
    output state_t                fsm_state
);

    localparam int PHASE_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W   = $clog2(WORD_WIDTH + 1);

    localparam logic [PHASE_W-1:0] PHASE_LOAD = PHASE_W'(CLK_DIV);
    localparam logic [7:0]         GAP_LOAD   = 8'(GAP_CYCLES);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(WORD_WIDTH - 1);
    localparam bit                 NO_GAP     = (GAP_CYCLES == 0);

`ifdef SPI_TX_CS_EN
    if (GAP_CYCLES < 1) begin : g_gap_check
        $error("spi_master_tx: GAP_CYCLES must be >= 1 when chip select is enabled");
    end
`endif

    state_t                state;
    // Holds the bits still to be sent after the one currently on spi_mosi, so the
    // register is one bit narrower than the word.
    logic [WORD_WIDTH-2:0] shift;
    logic [BIT_W-1:0]      bit_cnt;

    logic accept;
    logic phase_load;
    logic phase_expire;
    logic gap_expire;
    logic high_end;
    logic last_bit_end;

    assign accept       = in_valid && in_ready && (state == ST_IDLE);
    assign high_end     = (state == ST_HIGH) && phase_expire;
    assign last_bit_end = high_end && (bit_cnt == LAST_BIT);

    // Each LOW and HIGH phase reloads the half-period timer on entry.
    assign phase_load = accept
                     || ((state == ST_LOW) && phase_expire)
                     || (high_end && (bit_cnt != LAST_BIT));

    spi_half_period_timer #(
        .WIDTH(PHASE_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (phase_load),
        .load_val (PHASE_LOAD),
        .expire   (phase_expire)
    );

    spi_half_period_timer #(
        .WIDTH(8)
    ) u_gap_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (last_bit_end),
        .load_val (GAP_LOAD),
        .expire   (gap_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
`ifdef SPI_TX_CS_EN
            spi_cs_n <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_LOW;
                        shift    <= in_data[WORD_WIDTH-2:0];
                        spi_mosi <= in_data[WORD_WIDTH-1];
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
`ifdef SPI_TX_CS_EN
                        spi_cs_n <= 1'b0;
`endif
                    end else begin
                        // Rises on the first edge after reset release, so a word
                        // offered during release is not taken.
                        in_ready <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (phase_expire) begin
                        state   <= ST_HIGH;
                        spi_clk <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_expire) begin
                        spi_clk <= 1'b0;
                        bit_cnt <= bit_cnt + 1'b1;
                        shift   <= {shift[WORD_WIDTH-3:0], 1'b0};
                        if (bit_cnt == LAST_BIT) begin
                            spi_mosi <= 1'b0;
`ifdef SPI_TX_CS_EN
                            spi_cs_n <= 1'b1;
`endif
                            if (NO_GAP) begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                in_ready <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            state    <= ST_LOW;
                            spi_mosi <= shift[WORD_WIDTH-2];
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_expire) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign word_done = last_bit_end;
    assign fsm_state = state;

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx. Two instances: A (CLK_DIV=1, GAP_CYCLES=2) for the
// handshake, back-to-back, busy-ignore and mid-word reset cases; B (CLK_DIV=3, minimal gap)
// for phase-length and back-to-back timing. A behavioural SPI slave per instance rebuilds
// words on spi_clk rises and checks them against an expected queue filled by the driver.
module tb_spi_master_tx;
    import spi_tx_pkg::*;

    localparam int W     = 16;
    localparam int A_DIV = 1;
    localparam int A_GAP = 2;
    localparam int B_DIV = 3;
`ifdef SPI_TX_CS_EN
    localparam int B_GAP = 1;
`else
    localparam int B_GAP = 0;
`endif
    localparam int PERIOD = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #(PERIOD/2) clk = ~clk;

    logic [W-1:0] a_data, b_data;
    logic a_valid, a_ready, a_sclk, a_mosi, a_busy, a_done;
    logic b_valid, b_ready, b_sclk, b_mosi, b_busy, b_done;
    state_t a_state, b_state;
`ifdef SPI_TX_CS_EN
    logic a_cs_n, b_cs_n;
`endif

    spi_master_tx #(.WORD_WIDTH(W), .CLK_DIV(A_DIV), .GAP_CYCLES(A_GAP)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .spi_clk(a_sclk), .spi_mosi(a_mosi), .busy(a_busy),
        .word_done(a_done),
`ifdef SPI_TX_CS_EN
        .spi_cs_n(a_cs_n),
`endif
        .fsm_state(a_state)
    );

    spi_master_tx #(.WORD_WIDTH(W), .CLK_DIV(B_DIV), .GAP_CYCLES(B_GAP)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .spi_clk(b_sclk), .spi_mosi(b_mosi), .busy(b_busy),
        .word_done(b_done),
`ifdef SPI_TX_CS_EN
        .spi_cs_n(b_cs_n),
`endif
        .fsm_state(b_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] a_exp_q[$];
    logic [W-1:0] b_exp_q[$];
    int a_done_cnt = 0;
    int b_done_cnt = 0;
    int a_rises    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    // ---------------- slave models / monitors ----------------
    logic [W-1:0] a_sl_shift = '0;
    int           a_sl_bits  = 0;
    always @(posedge a_sclk or negedge reset_n) begin
        if (!reset_n) begin
            a_sl_shift = '0;
            a_sl_bits  = 0;
        end else begin
            a_sl_shift = {a_sl_shift[W-2:0], a_mosi};
            a_sl_bits++;
            if (a_sl_bits == W) begin
                a_sl_bits = 0;
                if (a_exp_q.size() == 0) fail_now("a_word_unexpected");
                else check("a_word", a_sl_shift, a_exp_q.pop_front());
            end
        end
    end

    logic [W-1:0] b_sl_shift = '0;
    int           b_sl_bits  = 0;
    always @(posedge b_sclk or negedge reset_n) begin
        if (!reset_n) begin
            b_sl_shift = '0;
            b_sl_bits  = 0;
        end else begin
            b_sl_shift = {b_sl_shift[W-2:0], b_mosi};
            b_sl_bits++;
            if (b_sl_bits == W) begin
                b_sl_bits = 0;
                if (b_exp_q.size() == 0) fail_now("b_word_unexpected");
                else check("b_word", b_sl_shift, b_exp_q.pop_front());
            end
        end
    end

    always @(posedge a_sclk) a_rises++;

    always @(negedge clk) begin
        if (a_done === 1'b1) a_done_cnt++;
        if (b_done === 1'b1) b_done_cnt++;
    end

    // Every spi_clk phase of B while shifting must last B_DIV clk cycles, and mosi must
    // not change on the cycle spi_clk rises.
    logic b_act, b_prev_act, b_prev_lvl, b_prev_mosi;
    int   b_run;
    always @(negedge clk) begin
        if (!reset_n) begin
            b_prev_act = 1'b0;
            b_run      = 0;
        end else begin
            b_act = (b_state == ST_LOW) || (b_state == ST_HIGH);
            if (b_act && b_prev_act && (b_sclk == b_prev_lvl)) begin
                b_run++;
            end else begin
                if (b_prev_act) check("b_phase_len", b_run, B_DIV);
                if (b_act && b_prev_act && b_sclk && !b_prev_lvl)
                    check("b_mosi_stable_rise", b_mosi, b_prev_mosi);
                b_run = 1;
            end
            b_prev_act  = b_act;
            b_prev_lvl  = b_sclk;
            b_prev_mosi = b_mosi;
        end
    end

`ifdef SPI_TX_CS_EN
    int a_cs_run = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            a_cs_run = 0;
        end else begin
            if (a_cs_n == 1'b0) begin
                a_cs_run++;
            end else begin
                if (a_cs_run != 0) check("a_cs_low_len", a_cs_run, 2*A_DIV*W);
                a_cs_run = 0;
            end
            if (a_state == ST_GAP) check("a_cs_high_in_gap", a_cs_n, 1);
        end
    end
`endif

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit sel, input logic [W-1:0] d, input bit hold,
                        input bit expect_w, output time t_acc);
        int n = 0;
        if (sel) begin b_data = d; b_valid = 1'b1; end
        else     begin a_data = d; a_valid = 1'b1; end
        while (((sel ? b_ready : a_ready) !== 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now(sel ? "b_accept_timeout" : "a_accept_timeout");
        if (expect_w) begin
            if (sel) b_exp_q.push_back(d);
            else     a_exp_q.push_back(d);
        end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        check(sel ? "b_mosi_first_bit" : "a_mosi_first_bit", sel ? b_mosi : a_mosi, d[W-1]);
        check(sel ? "b_busy_after_accept" : "a_busy_after_accept", sel ? b_busy : a_busy, 1);
        check(sel ? "b_ready_after_accept" : "a_ready_after_accept", sel ? b_ready : a_ready, 0);
        if (sel) begin
            if (!hold) b_valid = 1'b0;
            b_data = ~d;
        end else begin
            if (!hold) a_valid = 1'b0;
            a_data = ~d;
        end
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while (((sel ? b_ready : a_ready) !== 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now(sel ? "b_idle_timeout" : "a_idle_timeout");
    endtask

    initial begin
        #(200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        time t1, t2;
        int  start, n;

        reset_n = 1'b0;
        a_valid = 1'b1;
        a_data  = 16'h1234;
        b_valid = 1'b0;
        b_data  = '0;
        repeat (3) @(negedge clk);

        check("rst_a_ready", a_ready, 0);
        check("rst_a_sclk", a_sclk, 0);
        check("rst_a_mosi", a_mosi, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_state", a_state, ST_IDLE);
        check("rst_b_ready", b_ready, 0);

        // in_valid already high while reset releases: the release edge must not accept.
        reset_n = 1'b1;
        @(negedge clk);
        check("a_ready_after_release", a_ready, 1);
        check("a_no_accept_on_release", a_busy, 0);
        a_exp_q.push_back(16'h1234);
        @(negedge clk);
        check("a_busy_first_word", a_busy, 1);
        check("a_mosi_first_word", a_mosi, 0);
        check("a_ready_first_word", a_ready, 0);
        a_valid = 1'b0;
        a_data  = 16'hFFFF;
        wait_idle(1'b0);
        check("a_done_after_one_word", a_done_cnt, 1);

        // Back-to-back with in_valid held high.
        send(1'b0, 16'hABCD, 1'b1, 1'b1, t1);
        send(1'b0, 16'h5A5A, 1'b0, 1'b1, t2);
        check("a_b2b_interval", 32'((t2 - t1) / PERIOD), 2*A_DIV*W + A_GAP + 1);

        // Inputs wiggling while busy are ignored.
        send(1'b0, 16'hC3C3, 1'b0, 1'b1, t1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_valid = 1'($urandom_range(0, 1));
            a_data  = 16'($urandom_range(0, 65535));
            check("a_ready_low_while_busy", a_ready, 0);
        end
        a_valid = 1'b0;
        wait_idle(1'b0);

        // Reset after 7 bits of an all-ones word: outputs must clear immediately.
        start = a_rises;
        send(1'b0, 16'hFFFF, 1'b0, 1'b0, t1);
        n = 0;
        while (a_rises < start + 7 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail_now("a_seven_bits_timeout");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_sclk", a_sclk, 0);
        check("midrst_mosi", a_mosi, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_ready", a_ready, 0);
        check("midrst_state", a_state, ST_IDLE);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(1'b0, 16'h0001, 1'b0, 1'b1, t1);
        wait_idle(1'b0);

        // Instance B: slower clock, phase lengths checked by the monitor.
        send(1'b1, 16'h3C96, 1'b1, 1'b1, t1);
        send(1'b1, 16'h8001, 1'b0, 1'b1, t2);
        check("b_b2b_interval", 32'((t2 - t1) / PERIOD), 2*B_DIV*W + B_GAP + 1);
        wait_idle(1'b1);

        repeat (5) @(negedge clk);
        check("a_queue_drained", a_exp_q.size(), 0);
        check("b_queue_drained", b_exp_q.size(), 0);
        check("a_done_total", a_done_cnt, 5);
        check("b_done_total", b_done_cnt, 2);
`ifdef SPI_TX_CS_EN
        check("b_cs_idle_high", b_cs_n, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
